alu_iter: RTL and testbench

- Execution unit directly downstream of the ALU control decoder. It consumes the 4-bit alucontrol code together with the register/immediate operands and produces the result and zero flag.
- Logical, add/sub and sltu operations complete in one cycle.
- Shifts (sll/srl) run iteratively, one bit position per cycle, to save area.
- A start/busy/done handshake lets the control path stall the datapath while a shift is in flight.

---
 rtl/alu_iter_if.sv | 26 ++
 rtl/alu_iter.sv | 82 ++++++++
 tb/tb_alu_iter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_iter_if.sv
// alu_iter_if: operation request / completion bundle between the control path and alu_iter.
interface alu_iter_if #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
);
   logic             start;
   logic [3:0]       alucontrol;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [SHW-1:0]   shamt;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             illegal;

   modport master (
      output start, alucontrol, a, b, shamt,
      input  busy, done, result, zero, illegal
   );

   modport slave (
      input  start, alucontrol, a, b, shamt,
      output busy, done, result, zero, illegal
   );
endinterface

// File: rtl/alu_iter.sv
// alu_iter: ALU with single-cycle logic/arith ops and iterative one-bit-per-cycle sll/srl.
module alu_iter #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input logic        clk,
   input logic        reset,
   alu_iter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, next;
   logic [WIDTH-1:0] sreg, sreg_nxt, alu_res, result;
   logic [SHW-1:0]   cnt;
   logic             left, legal, is_shift, long_shift, accept, finish, zero, illegal;

   assign accept     = bus.start && state != SHIFT;
   assign is_shift   = bus.alucontrol == 4'b1010 || bus.alucontrol == 4'b1100;
   assign long_shift = is_shift && bus.shamt != '0;
   assign finish     = state == SHIFT && cnt == SHW'(1);
   assign sreg_nxt   = left ? sreg << 1 : sreg >> 1;

   assign bus.busy    = state == SHIFT;
   assign bus.done    = state == DONE;
   assign bus.result  = result;
   assign bus.zero    = zero;
   assign bus.illegal = illegal;

   // shift codes pass b through here; this is the shamt=0 result
   always_comb begin
      alu_res = '0;
      legal   = 1'b1;
      case (bus.alucontrol)
         4'b0000: alu_res = bus.a & bus.b;
         4'b0001: alu_res = bus.a | bus.b;
         4'b0010: alu_res = bus.a + bus.b;
         4'b0110: alu_res = bus.a - bus.b;
         4'b0111: alu_res = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
         4'b1010, 4'b1100: alu_res = bus.b;
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      next = IDLE;
      if (state == SHIFT) next = finish ? DONE : SHIFT;
      else if (accept) next = long_shift ? SHIFT : DONE;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sreg    <= '0;
         cnt     <= '0;
         left    <= 1'b0;
         result  <= '0;
         zero    <= 1'b1;
         illegal <= 1'b0;
      end else if (accept) begin
         if (long_shift) begin
            sreg <= bus.b;
            cnt  <= bus.shamt;
            left <= bus.alucontrol == 4'b1010;
         end else begin
            result  <= alu_res;
            zero    <= alu_res == '0;
            illegal <= !legal;
         end
      end else if (state == SHIFT) begin
         sreg <= sreg_nxt;
         cnt  <= cnt - SHW'(1);
         if (finish) begin
            result  <= sreg_nxt;
            zero    <= sreg_nxt == '0;
            illegal <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed self-checking bench for alu_iter, one task per scenario.
module tb_alu_iter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int tests = 0;
   int fails = 0;
   int lat, nbusy;

   alu_iter_if #(.WIDTH(32), .SHW(5)) bus ();
   alu_iter #(.WIDTH(32), .SHW(5)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
      bus.start = 1'b1;
      bus.alucontrol = op;
      bus.a = a;
      bus.b = b;
      bus.shamt = sh;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   task automatic measure();
      lat = 0;
      nbusy = 0;
      while (lat <= 100) begin
         @(negedge clk);
         lat++;
         if (bus.busy) nbusy++;
         if (bus.done) break;
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b0;
      bus.alucontrol = 4'b0;
      bus.a = '0;
      bus.b = '0;
      bus.shamt = '0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      tests++;
      if ({bus.busy, bus.done, bus.result, bus.zero, bus.illegal} !== {2'b00, 32'h0, 2'b10}) begin
         fails++;
         $display("FAIL reset_state: got busy=%b done=%b result=%h zero=%b illegal=%b, expected 0 0 0 1 0",
                  bus.busy, bus.done, bus.result, bus.zero, bus.illegal);
      end
      reset = 1'b0;
   endtask

   task automatic test_add_sub();
      issue(4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd0);
      measure();
      tests++;
      if ({lat, nbusy, bus.result, bus.zero} !== {32'd1, 32'd0, 32'h8000_0000, 1'b0}) begin
         fails++;
         $display("FAIL add: got lat=%0d busy=%0d result=%h zero=%b, expected 1 0 80000000 0", lat, nbusy, bus.result, bus.zero);
      end
      issue(4'b0110, 32'd5, 32'd5, 5'd0);
      measure();
      tests++;
      if ({lat, bus.result, bus.zero} !== {32'd1, 32'h0, 1'b1}) begin
         fails++;
         $display("FAIL sub: got lat=%0d result=%h zero=%b, expected 1 0 1", lat, bus.result, bus.zero);
      end
   endtask

   task automatic test_logic();
      issue(4'b0000, 32'h0000_00F0, 32'h0000_003C, 5'd7);
      measure();
      tests++;
      if ({lat, bus.result} !== {32'd1, 32'h0000_0030}) begin
         fails++;
         $display("FAIL and: got lat=%0d result=%h, expected 1 00000030", lat, bus.result);
      end
      issue(4'b0001, 32'h0000_00F0, 32'h0000_000F, 5'd0);
      measure();
      tests++;
      if ({lat, bus.result, bus.zero} !== {32'd1, 32'h0000_00FF, 1'b0}) begin
         fails++;
         $display("FAIL or: got lat=%0d result=%h zero=%b, expected 1 000000ff 0", lat, bus.result, bus.zero);
      end
   endtask

   task automatic test_sltu();
      issue(4'b0111, 32'h1, 32'hFFFF_FFFF, 5'd0);
      measure();
      tests++;
      if ({lat, bus.result, bus.zero} !== {32'd1, 32'h1, 1'b0}) begin
         fails++;
         $display("FAIL sltu_lt: got lat=%0d result=%h zero=%b, expected 1 00000001 0", lat, bus.result, bus.zero);
      end
      issue(4'b0111, 32'hFFFF_FFFF, 32'h1, 5'd0);
      measure();
      tests++;
      if ({lat, bus.result, bus.zero} !== {32'd1, 32'h0, 1'b1}) begin
         fails++;
         $display("FAIL sltu_ge: got lat=%0d result=%h zero=%b, expected 1 0 1", lat, bus.result, bus.zero);
      end
   endtask

   task automatic test_shift();
      issue(4'b1010, 32'h0, 32'h1, 5'd31);
      measure();
      tests++;
      if ({lat, nbusy, bus.result, bus.zero} !== {32'd32, 32'd31, 32'h8000_0000, 1'b0}) begin
         fails++;
         $display("FAIL sll31: got lat=%0d busy=%0d result=%h zero=%b, expected 32 31 80000000 0", lat, nbusy, bus.result, bus.zero);
      end
      issue(4'b1100, 32'hFFFF_FFFF, 32'h8000_0000, 5'd4);
      measure();
      tests++;
      if ({lat, nbusy, bus.result} !== {32'd5, 32'd4, 32'h0800_0000}) begin
         fails++;
         $display("FAIL srl4: got lat=%0d busy=%0d result=%h, expected 5 4 08000000", lat, nbusy, bus.result);
      end
      @(negedge clk);
      tests++;
      if ({bus.done, bus.busy, bus.result} !== {2'b00, 32'h0800_0000}) begin
         fails++;
         $display("FAIL done_pulse: got done=%b busy=%b result=%h, expected 0 0 08000000", bus.done, bus.busy, bus.result);
      end
   endtask

   task automatic test_shamt0_illegal();
      issue(4'b1010, 32'h1234_5678, 32'hDEAD_BEEF, 5'd0);
      measure();
      tests++;
      if ({lat, nbusy, bus.result} !== {32'd1, 32'd0, 32'hDEAD_BEEF}) begin
         fails++;
         $display("FAIL shamt0: got lat=%0d busy=%0d result=%h, expected 1 0 deadbeef", lat, nbusy, bus.result);
      end
      issue(4'b0011, 32'h1, 32'h2, 5'd3);
      measure();
      tests++;
      if ({lat, bus.illegal, bus.result, bus.zero} !== {32'd1, 1'b1, 32'h0, 1'b1}) begin
         fails++;
         $display("FAIL illegal: got lat=%0d illegal=%b result=%h zero=%b, expected 1 1 0 1", lat, bus.illegal, bus.result, bus.zero);
      end
      issue(4'b0010, 32'd3, 32'd4, 5'd0);
      measure();
      tests++;
      if ({bus.illegal, bus.result} !== {1'b0, 32'd7}) begin
         fails++;
         $display("FAIL illegal_clear: got illegal=%b result=%h, expected 0 00000007", bus.illegal, bus.result);
      end
      issue(4'b1111, 32'h1, 32'h2, 5'd3);
      measure();
      issue(4'b1100, 32'h0, 32'h0000_0100, 5'd8);
      measure();
      tests++;
      if ({lat, bus.illegal, bus.result, bus.zero} !== {32'd9, 1'b0, 32'h1, 1'b0}) begin
         fails++;
         $display("FAIL shift_clears_illegal: got lat=%0d illegal=%b result=%h zero=%b, expected 9 0 00000001 0", lat, bus.illegal, bus.result, bus.zero);
      end
   endtask

   task automatic test_ignore_start();
      logic [31:0] mid;
      issue(4'b1100, 32'h0, 32'hF000_0000, 5'd10);
      lat = 0;
      mid = 32'hFFFF_FFFF;
      while (lat <= 100) begin
         @(negedge clk);
         lat++;
         if (lat == 3) begin
            mid = bus.result;
            bus.start = 1'b1;
            bus.alucontrol = 4'b0010;
            bus.a = 32'd1;
            bus.b = 32'd2;
            bus.shamt = 5'd3;
         end
         if (lat == 4) begin
            bus.start = 1'b0;
            bus.alucontrol = 4'b1010;
            bus.b = 32'h0000_0001;
            bus.shamt = 5'd1;
         end
         if (bus.done) break;
      end
      tests++;
      if (mid !== 32'h1) begin
         fails++;
         $display("FAIL no_mid_update: got result=%h mid-shift, expected 00000001", mid);
      end
      tests++;
      if ({lat, bus.result} !== {32'd11, 32'h003C_0000}) begin
         fails++;
         $display("FAIL start_in_shift: got lat=%0d result=%h, expected 11 003c0000", lat, bus.result);
      end
   endtask

   task automatic test_back_to_back();
      issue(4'b0010, 32'd2, 32'd3, 5'd0);
      tests++;
      if ({bus.done, bus.result} !== {1'b1, 32'd5}) begin
         fails++;
         $display("FAIL back_to_back: got done=%b result=%h, expected 1 00000005", bus.done, bus.result);
      end
      @(negedge clk);
      issue(4'b1010, 32'd0, 32'h0000_0003, 5'd2);
      measure();
      tests++;
      if ({lat, nbusy, bus.result} !== {32'd3, 32'd2, 32'h0000_000C}) begin
         fails++;
         $display("FAIL b2b_shift: got lat=%0d busy=%0d result=%h, expected 3 2 0000000c", lat, nbusy, bus.result);
      end
   endtask

   task automatic test_reset_mid();
      int ndone;
      issue(4'b1010, 32'd0, 32'h0000_0003, 5'd8);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      tests++;
      if ({bus.busy, bus.done, bus.result, bus.zero, bus.illegal} !== {2'b00, 32'h0, 2'b10}) begin
         fails++;
         $display("FAIL reset_mid: got busy=%b done=%b result=%h zero=%b illegal=%b, expected 0 0 0 1 0",
                  bus.busy, bus.done, bus.result, bus.zero, bus.illegal);
      end
      @(negedge clk);
      reset = 1'b0;
      ndone = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.done || bus.busy) ndone++;
      end
      tests++;
      if (ndone !== 0) begin
         fails++;
         $display("FAIL no_done_after_reset: got %0d active cycles, expected 0", ndone);
      end
      issue(4'b0010, 32'd1, 32'd1, 5'd0);
      measure();
      tests++;
      if ({lat, bus.result, bus.zero} !== {32'd1, 32'd2, 1'b0}) begin
         fails++;
         $display("FAIL after_reset: got lat=%0d result=%h zero=%b, expected 1 00000002 0", lat, bus.result, bus.zero);
      end
   endtask

   initial begin
      test_reset();
      @(negedge clk);
      test_add_sub();
      test_logic();
      test_sltu();
      test_shift();
      test_shamt0_illegal();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
